// File: rtl/tlb_op_ctrl_if.sv
// TLB instruction controller bus: request/response handshake toward the
// pipeline plus the strobe/result signals exchanged with the TLB array.
interface tlb_op_ctrl_if #(
  parameter int unsigned TLBNUM = 16
);
  localparam int unsigned IW = (TLBNUM > 1) ? $clog2(TLBNUM) : 1;

  // request side
  logic          op_valid;
  logic [2:0]    op_code;
  logic [4:0]    inv_op;
  logic          op_ready;
  logic          op_done;
  logic          op_err;
  logic          res_e;
  logic [IW-1:0] res_index;
  logic          busy;

  // TLB array side
  logic          tlb_we;
  logic          tlb_fill_mode;
  logic [IW-1:0] tlb_f_index;
  logic          tlb_check_mode;
  logic [2:0]    tlb_clear_mem;
  logic          tlb_rs_e;
  logic [IW-1:0] tlb_s_index;

  // requester / TLB-model side
  modport master (
    output op_valid, op_code, inv_op, tlb_rs_e, tlb_s_index,
    input  op_ready, op_done, op_err, res_e, res_index, busy,
           tlb_we, tlb_fill_mode, tlb_f_index, tlb_check_mode, tlb_clear_mem
  );

  // controller side
  modport slave (
    input  op_valid, op_code, inv_op, tlb_rs_e, tlb_s_index,
    output op_ready, op_done, op_err, res_e, res_index, busy,
           tlb_we, tlb_fill_mode, tlb_f_index, tlb_check_mode, tlb_clear_mem
  );
endinterface

// File: rtl/tlb_op_ctrl.sv
// TLB instruction controller: sequences SRCH/RD/WR/FILL/INV through a fixed
// IDLE -> EXEC -> DONE walk, driving one-cycle TLB strobes in EXEC and
// capturing search/read results at the end of EXEC.
module tlb_op_ctrl #(
  parameter int unsigned TLBNUM = 16
) (
  input  logic         clk,
  input  logic         rstn,
  tlb_op_ctrl_if.slave bus
);
  localparam int unsigned   IW        = (TLBNUM > 1) ? $clog2(TLBNUM) : 1;
  localparam logic [IW-1:0] FILL_LAST = IW'(TLBNUM - 1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
  typedef enum logic [2:0] {
    OP_SRCH = 3'd0,
    OP_RD   = 3'd1,
    OP_WR   = 3'd2,
    OP_FILL = 3'd3,
    OP_INV  = 3'd4
  } op_e;

  state_e        state, state_nx;
  logic [2:0]    op_q;
  logic [4:0]    inv_q;
  logic [IW-1:0] fill_cnt;
  logic          res_e_q;
  logic [IW-1:0] res_idx_q;
  logic          err_q;

  logic          we_c;
  logic          fill_mode_c;
  logic          check_mode_c;
  logic [2:0]    clear_c;
  logic          exec_err_c;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and EXEC-cycle TLB strobes
  always_comb begin
    state_nx     = state;
    we_c         = 1'b0;
    fill_mode_c  = 1'b0;
    check_mode_c = 1'b0;
    clear_c      = '0;
    exec_err_c   = 1'b0;
    unique case (state)
      IDLE: if (bus.op_valid) state_nx = EXEC;
      EXEC: begin
        state_nx = DONE;
        case (op_q)
          OP_SRCH: check_mode_c = 1'b1;
          OP_RD:   check_mode_c = 1'b0;
          OP_WR:   we_c = 1'b1;
          OP_FILL: begin
            we_c        = 1'b1;
            fill_mode_c = 1'b1;
          end
          OP_INV: begin
            // inv_op 0 and 1 both clear everything; 0 on the bus means idle
            if (inv_q <= 5'd6) clear_c = (inv_q[2:0] == 3'd0) ? 3'd1 : inv_q[2:0];
            else               exec_err_c = 1'b1;
          end
          default: exec_err_c = 1'b1;
        endcase
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request latch on accept
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_q  <= '0;
      inv_q <= '0;
    end else if (state == IDLE && bus.op_valid) begin
      op_q  <= bus.op_code;
      inv_q <= bus.inv_op;
    end
  end

  // Result capture at the end of EXEC; error flag lives only during DONE
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res_e_q   <= 1'b0;
      res_idx_q <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= (state == EXEC) && exec_err_c;
      if (state == EXEC && op_q == OP_SRCH) begin
        res_e_q   <= bus.tlb_rs_e;
        res_idx_q <= bus.tlb_s_index;
      end else if (state == EXEC && op_q == OP_RD) begin
        res_e_q <= bus.tlb_rs_e;
      end
    end
  end

  // Free-running fill counter used as a pseudo-random replacement index
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                      fill_cnt <= '0;
    else if (fill_cnt == FILL_LAST) fill_cnt <= '0;
    else                            fill_cnt <= fill_cnt + 1'b1;
  end

  assign bus.op_ready       = (state == IDLE);
  assign bus.busy           = (state != IDLE);
  assign bus.op_done        = (state == DONE);
  assign bus.op_err         = err_q;
  assign bus.res_e          = res_e_q;
  assign bus.res_index      = res_idx_q;
  assign bus.tlb_we         = we_c;
  assign bus.tlb_fill_mode  = fill_mode_c;
  assign bus.tlb_f_index    = fill_cnt;
  assign bus.tlb_check_mode = check_mode_c;
  assign bus.tlb_clear_mem  = clear_c;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl with a result scoreboard popped on op_done.
module tb_tlb_op_ctrl;
  localparam int unsigned TLBNUM = 16;

  typedef struct packed {
    logic       err;
    logic       res_e;
    logic [3:0] idx;
  } exp_t;

  logic clk;
  logic rstn;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  // spec-level model of result registers and fill counter
  logic       m_res_e;
  logic [3:0] m_idx;
  logic [3:0] m_cnt;

  tlb_op_ctrl_if #(.TLBNUM(TLBNUM)) bus ();

  tlb_op_ctrl #(.TLBNUM(TLBNUM)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn)             m_cnt <= 4'd0;
    else if (m_cnt == 4'd15) m_cnt <= 4'd0;
    else                   m_cnt <= m_cnt + 4'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "/ready"},  32'(bus.op_ready), 1);
    chk({tag, "/busy"},   32'(bus.busy), 0);
    chk({tag, "/done"},   32'(bus.op_done), 0);
    chk({tag, "/err"},    32'(bus.op_err), 0);
    chk({tag, "/we"},     32'(bus.tlb_we), 0);
    chk({tag, "/fm"},     32'(bus.tlb_fill_mode), 0);
    chk({tag, "/cm"},     32'(bus.tlb_check_mode), 0);
    chk({tag, "/clr"},    32'(bus.tlb_clear_mem), 0);
    chk({tag, "/res_e"},  32'(bus.res_e), 0);
    chk({tag, "/res_ix"}, 32'(bus.res_index), 0);
    chk({tag, "/f_ix"},   32'(bus.tlb_f_index), 0);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "/sb_empty"}, 32'(sb_q.size()), 1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "/err"},    32'(bus.op_err), 32'(e.err));
      chk({tag, "/res_e"},  32'(bus.res_e), 32'(e.res_e));
      chk({tag, "/res_ix"}, 32'(bus.res_index), 32'(e.idx));
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] code, input logic [4:0] inv,
                        input logic rs_e, input logic [3:0] sidx, input logic abort);
    logic       x_we, x_fm, x_cm, x_err;
    logic [2:0] x_clr;
    int         w;
    x_we  = (code == 3'd2) || (code == 3'd3);
    x_fm  = (code == 3'd3);
    x_cm  = (code == 3'd0);
    x_err = (code > 3'd4) || (code == 3'd4 && inv > 5'd6);
    x_clr = (code == 3'd4 && inv <= 5'd6) ? ((inv[2:0] == 3'd0) ? 3'd1 : inv[2:0]) : 3'd0;

    w = 0;
    while (!bus.op_ready && w < 10) begin
      @(posedge clk); #1;
      w++;
    end
    chk({name, "/ready"}, 32'(bus.op_ready), 1);
    bus.op_valid = 1'b1;
    bus.op_code  = code;
    bus.inv_op   = inv;

    // EXEC
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    bus.op_code  = ~code;
    bus.inv_op   = ~inv;
    chk({name, "/x_busy"}, 32'(bus.busy), 1);
    chk({name, "/x_rdy"},  32'(bus.op_ready), 0);
    chk({name, "/x_done"}, 32'(bus.op_done), 0);
    chk({name, "/x_we"},   32'(bus.tlb_we), 32'(x_we));
    chk({name, "/x_fm"},   32'(bus.tlb_fill_mode), 32'(x_fm));
    chk({name, "/x_cm"},   32'(bus.tlb_check_mode), 32'(x_cm));
    chk({name, "/x_clr"},  32'(bus.tlb_clear_mem), 32'(x_clr));
    if (x_fm) chk({name, "/x_fidx"}, 32'(bus.tlb_f_index), 32'(m_cnt));
    bus.tlb_rs_e    = rs_e;
    bus.tlb_s_index = sidx;

    if (abort) begin
      #2 rstn = 1'b0;
      #1;
      m_res_e = 1'b0;
      m_idx   = 4'd0;
      reset_checks({name, "/abort"});
      repeat (2) begin
        @(posedge clk); #1;
        chk({name, "/abort_done"}, 32'(bus.op_done), 0);
        chk({name, "/abort_we"},   32'(bus.tlb_we), 0);
      end
      rstn = 1'b1;
      return;
    end

    if (code == 3'd0) begin
      m_res_e = rs_e;
      m_idx   = sidx;
    end else if (code == 3'd1) begin
      m_res_e = rs_e;
    end
    sb_q.push_back('{err: x_err, res_e: m_res_e, idx: m_idx});

    // DONE
    @(posedge clk); #1;
    bus.tlb_rs_e    = ~rs_e;
    bus.tlb_s_index = ~sidx;
    chk({name, "/d_done"}, 32'(bus.op_done), 1);
    chk({name, "/d_busy"}, 32'(bus.busy), 1);
    chk({name, "/d_we"},   32'(bus.tlb_we), 0);
    chk({name, "/d_cm"},   32'(bus.tlb_check_mode), 0);
    chk({name, "/d_clr"},  32'(bus.tlb_clear_mem), 0);
    pop_check({name, "/d"});

    // back to IDLE
    @(posedge clk); #1;
    chk({name, "/i_done"}, 32'(bus.op_done), 0);
    chk({name, "/i_rdy"},  32'(bus.op_ready), 1);
  endtask

  initial begin
    int acc, wes, last_acc;
    rstn            = 1'b0;
    bus.op_valid    = 1'b0;
    bus.op_code     = 3'd0;
    bus.inv_op      = 5'd0;
    bus.tlb_rs_e    = 1'b0;
    bus.tlb_s_index = 4'd0;
    m_res_e         = 1'b0;
    m_idx           = 4'd0;

    repeat (2) @(posedge clk);
    #1;
    reset_checks("por");
    rstn = 1'b1;

    run_op("srch_hit", 3'd0, 5'd0, 1'b1, 4'd5, 1'b0);
    run_op("rd_e0",    3'd1, 5'd0, 1'b0, 4'd9, 1'b0);
    run_op("wr",       3'd2, 5'd0, 1'b1, 4'd2, 1'b0);

    for (int w = 0; w < 40 && m_cnt != 4'd14; w++) begin
      @(posedge clk); #1;
    end
    run_op("fill_a", 3'd3, 5'd0, 1'b0, 4'd0, 1'b0);
    run_op("fill_b", 3'd3, 5'd0, 1'b0, 4'd0, 1'b0);

    run_op("inv0",  3'd4, 5'd0, 1'b0, 4'd0, 1'b0);
    run_op("inv5",  3'd4, 5'd5, 1'b0, 4'd0, 1'b0);
    run_op("inv9",  3'd4, 5'd9, 1'b0, 4'd0, 1'b0);
    run_op("op6",   3'd6, 5'd0, 1'b0, 4'd0, 1'b0);
    run_op("rd_e1", 3'd1, 5'd0, 1'b1, 4'd7, 1'b0);

    // WR with op_valid held: one accept every third cycle
    acc = 0;
    wes = 0;
    last_acc = -1;
    bus.op_valid = 1'b1;
    bus.op_code  = 3'd2;
    for (int c = 0; c < 9; c++) begin
      if (bus.op_ready) begin
        acc++;
        if (last_acc >= 0) chk("hold/gap", 32'(c - last_acc), 3);
        last_acc = c;
        sb_q.push_back('{err: 1'b0, res_e: m_res_e, idx: m_idx});
      end
      @(posedge clk); #1;
      if (bus.tlb_we) wes++;
      if (bus.op_done) pop_check("hold/d");
    end
    bus.op_valid = 1'b0;
    chk("hold/accepts", 32'(acc), 3);
    chk("hold/we_pulses", 32'(wes), 3);
    chk("hold/sb_left", 32'(sb_q.size()), 0);

    run_op("wr_abort",   3'd2, 5'd0, 1'b0, 4'd0, 1'b1);
    run_op("srch_after", 3'd0, 5'd0, 1'b1, 4'd12, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
